data_memory_responder: RTL and testbench

// - Memory-side responder to the control unit's memory_read/memory_write strobes; owns the data RAM.
// - Loads: same-cycle combinational read with funct3 width/sign handling.
// - Stores: multi-cycle byte-masked write; write_done is held low during the write, so the core stalls its PC until the store commits.

---
 rtl/data_memory_responder_if.sv | 22 ++
 rtl/data_memory_responder.sv | 137 +++++++++++++
 tb/tb_data_memory_responder.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/data_memory_responder_if.sv
// Control-unit <-> data-memory bus: load/store strobes, access info, and the
// load result / store-complete / misalignment responses.
interface data_memory_responder_if;
  logic        memory_read;
  logic        memory_write;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        write_done;
  logic        misaligned;

  modport master (
    output memory_read, memory_write, funct3, address, write_data,
    input  read_data, write_done, misaligned
  );

  modport slave (
    input  memory_read, memory_write, funct3, address, write_data,
    output read_data, write_done, misaligned
  );
endinterface

// File: rtl/data_memory_responder.sv
// Data RAM responder: combinational loads, multi-cycle byte-masked stores that stall the PC.
// Optional macro MEM_MISALIGN_TRAP_EN: flag and reject misaligned accesses instead of aligning them.
module data_memory_responder #(
  parameter int DEPTH_WORDS   = 1024,
  parameter int WRITE_LATENCY = 2
) (
  input logic clk,
  input logic reset,
  data_memory_responder_if.slave mem
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(WRITE_LATENCY + 1);
  localparam logic [CW-1:0] LAST = CW'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   ram [DEPTH_WORDS];
  logic [AW-1:0] w_idx;
  logic [3:0]    w_mask, mask;
  logic [31:0]   w_data, lane_data;
  logic [31:0]   ea, rword, ext;
  logic [7:0]    lb;
  logic [15:0]   lh;
  logic          accept, ld_block, commit, write_done;
  logic          unused_hi;

`ifdef MEM_MISALIGN_TRAP_EN
  logic st_mis, ld_mis;
  assign st_mis   = (mem.funct3 == 3'b001 && mem.address[0]) ||
                    (mem.funct3 == 3'b010 && |mem.address[1:0]);
  assign ld_mis   = (mem.funct3[1:0] == 2'b01 && mem.address[0]) ||
                    (mem.funct3 == 3'b010 && |mem.address[1:0]);
  assign ea       = mem.address;
  assign accept   = mem.memory_write && !st_mis;
  assign ld_block = mem.memory_read && ld_mis;
  assign mem.misaligned = (state == IDLE) &&
                          ((mem.memory_write && st_mis) || (mem.memory_read && ld_mis));
`else
  logic is_half, is_word;
  assign is_half  = (mem.funct3[1:0] == 2'b01);
  assign is_word  = (mem.funct3 == 3'b010);
  // Silently align: drop the low bits the access width cannot use.
  assign ea       = {mem.address[31:2], mem.address[1] & ~is_word,
                     mem.address[0] & ~(is_word | is_half)};
  assign accept   = mem.memory_write;
  assign ld_block = 1'b0;
  assign mem.misaligned = 1'b0;
`endif

  assign unused_hi = ^ea[31:AW+2];

  // Loads: pure combinational read of the current RAM contents.
  assign rword = ram[ea[AW+1:2]];
  assign lb    = 8'(rword >> {ea[1:0], 3'b000});
  assign lh    = 16'(rword >> {ea[1], 4'b0000});

  always_comb begin
    ext = '0;
    case (mem.funct3)
      3'b000:  ext = {{24{lb[7]}}, lb};
      3'b100:  ext = {24'b0, lb};
      3'b001:  ext = {{16{lh[15]}}, lh};
      3'b101:  ext = {16'b0, lh};
      3'b010:  ext = rword;
      default: ext = '0;
    endcase
  end

  assign mem.read_data = (mem.memory_read && !ld_block) ? ext : '0;

  // Replicated lanes; the mask picks which copy lands.
  always_comb begin
    mask      = 4'b0000;
    lane_data = mem.write_data;
    case (mem.funct3)
      3'b000: begin
        mask      = 4'b0001 << ea[1:0];
        lane_data = {4{mem.write_data[7:0]}};
      end
      3'b001: begin
        mask      = 4'b0011 << {ea[1], 1'b0};
        lane_data = {2{mem.write_data[15:0]}};
      end
      3'b010:  mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    write_done = 1'b1;
    case (state)
      IDLE: if (accept) begin
        write_done = 1'b0;
        state_nxt  = WRITE;
      end
      WRITE: begin
        write_done = 1'b0;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mem.write_done = write_done;
  assign commit         = (state == WRITE) && (cnt == LAST) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && accept) cnt <= '0;
      else if (state == WRITE)     cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      w_idx  <= ea[AW+1:2];
      w_mask <= mask;
      w_data <= lane_data;
    end
  end

  // RAM has no reset; contents survive reset and aborted stores.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++)
        if (w_mask[b]) ram[w_idx][8*b +: 8] <= w_data[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized bench for data_memory_responder against a byte-array memory model.
module tb_data_memory_responder;
  localparam int DEPTH = 1024;
  localparam int WL    = 2;
  localparam int MB    = DEPTH * 4;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  data_memory_responder_if bus();

  data_memory_responder #(.DEPTH_WORDS(DEPTH), .WRITE_LATENCY(WL)) dut (
    .clk(clk), .reset(reset), .mem(bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mm [MB];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit mis(input logic [31:0] a, input logic [2:0] f3, input bit st);
    bit h, w;
    h = (f3 == 3'b001) || (!st && f3 == 3'b101);
    w = (f3 == 3'b010);
    return TRAP && ((h && a[0]) || (w && a[1:0] != 2'b00));
  endfunction

  function automatic int base(input logic [31:0] a, input logic [2:0] f3);
    int x;
    x = int'(a) & (MB - 1);
    if (f3[1:0] == 2'b01) x = x & ~1;
    if (f3 == 3'b010)     x = x & ~3;
    return x;
  endfunction

  function automatic logic [31:0] mload(input logic [31:0] a, input logic [2:0] f3);
    int x;
    logic [7:0]  b;
    logic [15:0] h;
    if (mis(a, f3, 1'b0)) return 32'h0;
    x = base(a, f3);
    b = mm[x];
    h = {mm[(x + 1) % MB], mm[x]};
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      3'b010:  return {mm[x + 3], mm[x + 2], mm[x + 1], mm[x]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic mstore(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    int x;
    x = base(a, f3);
    case (f3)
      3'b000: mm[x] = d[7:0];
      3'b001: begin mm[x] = d[7:0]; mm[x + 1] = d[15:8]; end
      3'b010: for (int i = 0; i < 4; i++) mm[x + i] = d[8*i +: 8];
      default: ;
    endcase
  endtask

  task automatic do_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d,
                          input string tag);
    int lows;
    logic [31:0] pa;
    lows = 0;
    pa   = a & ~32'h3;
    @(negedge clk);
    bus.memory_write = 1'b1; bus.memory_read = 1'b0;
    bus.funct3 = f3; bus.address = a; bus.write_data = d;
    #1;
    chk({tag, "_misflag"}, {31'b0, bus.misaligned}, {31'b0, mis(a, f3, 1'b1)});
    if (mis(a, f3, 1'b1)) begin
      chk({tag, "_wd_rej"}, {31'b0, bus.write_done}, 32'h1);
      bus.memory_write = 1'b0;
      return;
    end
    while (lows < 20) begin
      if (bus.write_done) break;
      lows++;
      @(negedge clk);
      if (!bus.write_done) begin
        // mid-store reads see the old word
        bus.memory_read = 1'b1; bus.funct3 = 3'b010; bus.address = pa;
        #1;
        chk({tag, "_old"}, bus.read_data, mload(pa, 3'b010));
      end
    end
    chk({tag, "_lat"}, lows, WL + 1);
    mstore(a, f3, d);
    bus.memory_read = 1'b1; bus.funct3 = f3; bus.address = a;
    #1;
    chk({tag, "_done_rd"}, bus.read_data, mload(a, f3));
    bus.memory_write = 1'b0; bus.memory_read = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input string tag,
                         output logic [31:0] got);
    @(negedge clk);
    bus.memory_read = 1'b1; bus.memory_write = 1'b0;
    bus.funct3 = f3; bus.address = a;
    #1;
    got = bus.read_data;
    chk({tag, "_rd"}, got, mload(a, f3));
    chk({tag, "_mis"}, {31'b0, bus.misaligned}, {31'b0, mis(a, f3, 1'b0)});
    chk({tag, "_wd"}, {31'b0, bus.write_done}, 32'h1);
    bus.memory_read = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, a;
    logic [2:0]  f3;
    bus.memory_read = 1'b0; bus.memory_write = 1'b0;
    bus.funct3 = 3'b0; bus.address = 32'h0; bus.write_data = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_wd",  {31'b0, bus.write_done}, 32'h1);
    chk("rst_mis", {31'b0, bus.misaligned}, 32'h0);
    chk("rst_rd",  bus.read_data, 32'h0);

    for (int w = 0; w < 64; w++) do_store(w * 4, 3'b010, $urandom, "init");

    do_store(32'h10, 3'b010, 32'hDEADBEEF, "sw10");
    do_load(32'h10, 3'b010, "lw10", got);
    chk("lw10_k", got, 32'hDEADBEEF);

    do_store(32'h10, 3'b010, 32'h0, "sw10z");
    do_store(32'h13, 3'b000, 32'h80, "sb13");
    do_load(32'h10, 3'b010, "lw10b", got);  chk("lw10b_k", got, 32'h80000000);
    do_load(32'h13, 3'b000, "lb13", got);   chk("lb13_k",  got, 32'hFFFFFF80);
    do_load(32'h13, 3'b100, "lbu13", got);  chk("lbu13_k", got, 32'h00000080);

    do_store(32'h22, 3'b001, 32'hBEEF, "sh22");
    do_load(32'h22, 3'b001, "lh22", got);   chk("lh22_k",  got, 32'hFFFFBEEF);
    do_load(32'h22, 3'b101, "lhu22", got);  chk("lhu22_k", got, 32'h0000BEEF);

    // reset during the second WRITE cycle aborts the store
    do_store(32'h30, 3'b010, 32'hA5A5A5A5, "sw30");
    @(negedge clk);
    bus.memory_write = 1'b1; bus.funct3 = 3'b010;
    bus.address = 32'h30; bus.write_data = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; bus.memory_write = 1'b0;
    #1;
    chk("abort_wd",  {31'b0, bus.write_done}, 32'h1);
    chk("abort_mis", {31'b0, bus.misaligned}, 32'h0);
    do_load(32'h30, 3'b010, "abort_lw", got);
    chk("abort_k", got, 32'hA5A5A5A5);

    do_store(32'h41, 3'b010, 32'hCAFEF00D, "sw41");
    do_load(32'h40, 3'b010, "lw40", got);
    if (!TRAP) chk("lw40_k", got, 32'hCAFEF00D);

    for (int i = 0; i < 300; i++) begin
      a  = $urandom_range(0, 255) | ($urandom_range(0, 3) << 12);
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) do_store(a, f3, $urandom, "rst");
      else                           do_load(a, f3, "rld", got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
